cache_axi_arbiter: RTL and testbench

- Shares one AXI3 master port between three requesters: the instruction cache read, the data cache read, and the data cache write.
- Sits between the cache/uncached path and the top-level AXI wrapper. The wrapper ties off constant fields: burst=INCR, lock/cache/prot=0, wid=awid.
- Read and write channels run independent FSMs. Each channel allows at most one transaction in flight.

---
 rtl/cache_axi_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_cache_axi_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_axi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_axi_arbiter
// Purpose  : Shares one AXI3 master between I-cache read, D-cache read and
//            D-cache write; independent single-outstanding read/write FSMs.
// Revision : 1.0
// ============================================================================
module cache_axi_arbiter #(
   parameter logic [3:0] ID_INST   = 4'd0,
   parameter logic [3:0] ID_DATA   = 4'd1,
   parameter int         RAW_BLOCK = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_rd_req,
   input  logic [31:0] inst_rd_addr,
   input  logic [3:0]  inst_rd_len,
   input  logic        data_rd_req,
   input  logic [31:0] data_rd_addr,
   input  logic [3:0]  data_rd_len,
   input  logic [2:0]  data_rd_size,
   output logic        inst_rd_gnt,
   output logic        data_rd_gnt,
   output logic        inst_rd_valid,
   output logic        data_rd_valid,
   output logic        rd_last,
   output logic [31:0] rd_data,
   input  logic        data_wr_req,
   input  logic [31:0] data_wr_addr,
   input  logic [3:0]  data_wr_len,
   input  logic [2:0]  data_wr_size,
   output logic        data_wr_gnt,
   input  logic [31:0] data_wr_data,
   input  logic [3:0]  data_wr_strb,
   output logic        data_wr_ready,
   output logic        data_wr_done,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [3:0]  arlen,
   output logic [2:0]  arsize,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [3:0]  awlen,
   output logic [2:0]  awsize,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   input  logic        bvalid,
   output logic        bready
);

   typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_DATA = 2'd2} rd_state_t;
   typedef enum logic [1:0] {W_IDLE = 2'd0, W_AW = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3} wr_state_t;

   rd_state_t   rd_state_q, rd_state_d;
   logic        rr_ptr_q, rr_ptr_d;
   logic        rd_owner_q, rd_owner_d;
   logic [3:0]  ar_id_q, ar_id_d;
   logic [31:0] ar_addr_q, ar_addr_d;
   logic [3:0]  ar_len_q, ar_len_d;
   logic [2:0]  ar_size_q, ar_size_d;

   wr_state_t   wr_state_q, wr_state_d;
   logic [3:0]  aw_id_q, aw_id_d;
   logic [31:0] aw_addr_q, aw_addr_d;
   logic [3:0]  aw_len_q, aw_len_d;
   logic [2:0]  aw_size_q, aw_size_d;
   logic [3:0]  wr_cnt_q, wr_cnt_d;
   logic        wr_done_q, wr_done_d;

   logic        data_elig;
   logic        pick_data;

   // A data read may not overtake a write that is pending or in flight.
   always_comb begin
      rd_state_d  = rd_state_q;
      rr_ptr_d    = rr_ptr_q;
      rd_owner_d  = rd_owner_q;
      ar_id_d     = ar_id_q;
      ar_addr_d   = ar_addr_q;
      ar_len_d    = ar_len_q;
      ar_size_d   = ar_size_q;
      inst_rd_gnt = 1'b0;
      data_rd_gnt = 1'b0;
      data_elig   = data_rd_req &&
                    !((RAW_BLOCK != 0) && ((wr_state_q != W_IDLE) || data_wr_req));
      pick_data   = data_elig && (!inst_rd_req || rr_ptr_q);
      case (rd_state_q)
         R_IDLE: begin
            if (inst_rd_req || data_elig) begin
               if (inst_rd_req && data_elig) rr_ptr_d = ~rr_ptr_q;
               rd_owner_d  = pick_data;
               ar_id_d     = pick_data ? ID_DATA : ID_INST;
               ar_addr_d   = pick_data ? data_rd_addr : inst_rd_addr;
               ar_len_d    = pick_data ? data_rd_len : inst_rd_len;
               ar_size_d   = pick_data ? data_rd_size : 3'd2;
               inst_rd_gnt = !pick_data;
               data_rd_gnt = pick_data;
               rd_state_d  = R_AR;
            end
         end
         R_AR:    if (arready) rd_state_d = R_DATA;
         R_DATA:  if (rvalid && rlast) rd_state_d = R_IDLE;
         default: rd_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      wr_state_d  = wr_state_q;
      aw_id_d     = aw_id_q;
      aw_addr_d   = aw_addr_q;
      aw_len_d    = aw_len_q;
      aw_size_d   = aw_size_q;
      wr_cnt_d    = wr_cnt_q;
      wr_done_d   = 1'b0;
      data_wr_gnt = 1'b0;
      case (wr_state_q)
         W_IDLE: begin
            if (data_wr_req) begin
               aw_id_d     = ID_DATA;
               aw_addr_d   = data_wr_addr;
               aw_len_d    = data_wr_len;
               aw_size_d   = data_wr_size;
               wr_cnt_d    = 4'd0;
               data_wr_gnt = 1'b1;
               wr_state_d  = W_AW;
            end
         end
         W_AW: if (awready) wr_state_d = W_DATA;
         W_DATA: begin
            if (wready) begin
               wr_cnt_d = wr_cnt_q + 4'd1;
               if (wr_cnt_q == aw_len_q) wr_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (bvalid) begin
               wr_done_d  = 1'b1;
               wr_state_d = W_IDLE;
            end
         end
         default: wr_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_state_q <= R_IDLE;
         rr_ptr_q   <= 1'b0;
         rd_owner_q <= 1'b0;
         ar_id_q    <= 4'd0;
         ar_addr_q  <= 32'd0;
         ar_len_q   <= 4'd0;
         ar_size_q  <= 3'd0;
         wr_state_q <= W_IDLE;
         aw_id_q    <= 4'd0;
         aw_addr_q  <= 32'd0;
         aw_len_q   <= 4'd0;
         aw_size_q  <= 3'd0;
         wr_cnt_q   <= 4'd0;
         wr_done_q  <= 1'b0;
      end else begin
         rd_state_q <= rd_state_d;
         rr_ptr_q   <= rr_ptr_d;
         rd_owner_q <= rd_owner_d;
         ar_id_q    <= ar_id_d;
         ar_addr_q  <= ar_addr_d;
         ar_len_q   <= ar_len_d;
         ar_size_q  <= ar_size_d;
         wr_state_q <= wr_state_d;
         aw_id_q    <= aw_id_d;
         aw_addr_q  <= aw_addr_d;
         aw_len_q   <= aw_len_d;
         aw_size_q  <= aw_size_d;
         wr_cnt_q   <= wr_cnt_d;
         wr_done_q  <= wr_done_d;
      end
   end

   assign arid          = ar_id_q;
   assign araddr        = ar_addr_q;
   assign arlen         = ar_len_q;
   assign arsize        = ar_size_q;
   assign arvalid       = (rd_state_q == R_AR);
   assign rready        = (rd_state_q == R_DATA);
   assign rd_data       = rready ? rdata : 32'd0;
   assign rd_last       = rready && rvalid && rlast;
   assign inst_rd_valid = rready && rvalid && !rd_owner_q;
   assign data_rd_valid = rready && rvalid && rd_owner_q;

   assign awid          = aw_id_q;
   assign awaddr        = aw_addr_q;
   assign awlen         = aw_len_q;
   assign awsize        = aw_size_q;
   assign awvalid       = (wr_state_q == W_AW);
   assign wvalid        = (wr_state_q == W_DATA);
   assign wdata         = wvalid ? data_wr_data : 32'd0;
   assign wstrb         = wvalid ? data_wr_strb : 4'd0;
   assign wlast         = wvalid && (wr_cnt_q == aw_len_q);
   assign data_wr_ready = wvalid && wready;
   assign bready        = (wr_state_q == W_RESP);
   assign data_wr_done  = wr_done_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_axi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_axi_arbiter
// Purpose  : Scoreboard bench with requester/AXI-slave models for the arbiter.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_cache_axi_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        inst_rd_req, data_rd_req, data_wr_req;
   logic [31:0] inst_rd_addr, data_rd_addr, data_wr_addr, data_wr_data;
   logic [3:0]  inst_rd_len, data_rd_len, data_wr_len, data_wr_strb;
   logic [2:0]  data_rd_size, data_wr_size;
   logic        inst_rd_gnt, data_rd_gnt, inst_rd_valid, data_rd_valid, rd_last;
   logic [31:0] rd_data;
   logic        data_wr_gnt, data_wr_ready, data_wr_done;
   logic [3:0]  arid, arlen, awid, awlen, wstrb;
   logic [31:0] araddr, awaddr, wdata, rdata;
   logic [2:0]  arsize, awsize;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

   cache_axi_arbiter #(.ID_INST(4'd0), .ID_DATA(4'd1), .RAW_BLOCK(1)) dut (
      .clk(clk), .rst(rst),
      .inst_rd_req(inst_rd_req), .inst_rd_addr(inst_rd_addr), .inst_rd_len(inst_rd_len),
      .data_rd_req(data_rd_req), .data_rd_addr(data_rd_addr), .data_rd_len(data_rd_len),
      .data_rd_size(data_rd_size),
      .inst_rd_gnt(inst_rd_gnt), .data_rd_gnt(data_rd_gnt),
      .inst_rd_valid(inst_rd_valid), .data_rd_valid(data_rd_valid),
      .rd_last(rd_last), .rd_data(rd_data),
      .data_wr_req(data_wr_req), .data_wr_addr(data_wr_addr), .data_wr_len(data_wr_len),
      .data_wr_size(data_wr_size), .data_wr_gnt(data_wr_gnt),
      .data_wr_data(data_wr_data), .data_wr_strb(data_wr_strb),
      .data_wr_ready(data_wr_ready), .data_wr_done(data_wr_done),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid),
      .arready(arready), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid),
      .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
      .wready(wready), .bvalid(bvalid), .bready(bready)
   );

   typedef struct { logic [31:0] addr; logic [3:0] len; logic [2:0] size; } req_t;
   typedef struct { logic [3:0] id; logic [31:0] addr; logic [3:0] len; logic [2:0] size; int held; } ar_t;
   typedef struct { int owner; logic [31:0] data; logic last; } rb_t;
   typedef struct { int owner; int gap; int min_done; } gnt_t;
   typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } wb_t;

   req_t iq[$], dq[$], wq[$];
   ar_t  ar_exp[$], aw_exp[$];
   rb_t  rb_exp[$];
   gnt_t g_exp[$];
   wb_t  wb_exp[$];
   int   done_exp[$], wg_exp[$];

   int checks = 0, errors = 0;
   int ar_delay = 1;
   logic wr_toggle = 1'b0;
   logic [31:0] wvec [16];
   logic [3:0]  wstrb_v = 4'h0;
   int wr_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   int   cyc = 0, last_rlast_cyc = -100, done_cnt = 0, ar_hold = 0;
   logic prev_bhs = 1'b0;
   initial begin
      ar_t a; rb_t b; gnt_t g; wb_t w;
      forever begin
         @(negedge clk);
         cyc++;
         if (data_wr_done) begin
            check("done_after_bresp", {63'd0, prev_bhs}, 64'd1);
            if (done_exp.size() == 0) check("done_unexpected", 64'd1, 64'd0);
            else void'(done_exp.pop_front());
            done_cnt++;
         end
         prev_bhs = bvalid && bready;
         if (inst_rd_gnt || data_rd_gnt) begin
            if (g_exp.size() == 0) check("rd_gnt_unexpected", 64'd1, 64'd0);
            else begin
               g = g_exp.pop_front();
               check("rd_gnt_owner", {62'd0, inst_rd_gnt, data_rd_gnt}, (g.owner == 0) ? 64'd2 : 64'd1);
               if (g.gap >= 0) check("rd_gnt_gap", 64'(cyc - last_rlast_cyc), 64'(g.gap));
               if (g.min_done > 0) check("rd_gnt_after_done", (done_cnt >= g.min_done) ? 64'd1 : 64'd0, 64'd1);
            end
         end
         if (data_wr_gnt) begin
            if (wg_exp.size() == 0) check("wr_gnt_unexpected", 64'd1, 64'd0);
            else void'(wg_exp.pop_front());
         end
         if (arvalid) ar_hold++;
         if (arvalid && arready) begin
            if (ar_exp.size() == 0) check("ar_unexpected", 64'd1, 64'd0);
            else begin
               a = ar_exp.pop_front();
               check("arid", 64'(arid), 64'(a.id));
               check("araddr", 64'(araddr), 64'(a.addr));
               check("arlen", 64'(arlen), 64'(a.len));
               check("arsize", 64'(arsize), 64'(a.size));
               if (a.held > 0) check("arvalid_held", 64'(ar_hold), 64'(a.held));
            end
            ar_hold = 0;
         end
         if (awvalid && awready) begin
            if (aw_exp.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
            else begin
               a = aw_exp.pop_front();
               check("awid", 64'(awid), 64'(a.id));
               check("awaddr", 64'(awaddr), 64'(a.addr));
               check("awlen", 64'(awlen), 64'(a.len));
               check("awsize", 64'(awsize), 64'(a.size));
            end
         end
         if (inst_rd_valid || data_rd_valid) begin
            if (rb_exp.size() == 0) check("rd_beat_unexpected", 64'd1, 64'd0);
            else begin
               b = rb_exp.pop_front();
               check("rd_beat_owner", {62'd0, inst_rd_valid, data_rd_valid}, (b.owner == 0) ? 64'd2 : 64'd1);
               check("rd_data", 64'(rd_data), 64'(b.data));
               check("rd_last", 64'(rd_last), 64'(b.last));
            end
            if (rd_last) last_rlast_cyc = cyc;
         end
         if (wvalid && wready) begin
            if (wb_exp.size() == 0) check("w_beat_unexpected", 64'd1, 64'd0);
            else begin
               w = wb_exp.pop_front();
               check("wdata", 64'(wdata), 64'(w.data));
               check("wstrb", 64'(wstrb), 64'(w.strb));
               check("wlast", 64'(wlast), 64'(w.last));
            end
         end
      end
   end

   // ---------------- requesters + AXI slave ----------------
   logic s_rst, s_igt, s_dgt, s_wgt, s_ar_hs, s_arv, s_r_hs, s_aw_hs, s_awv, s_wrdy, s_wl, s_b_hs;
   logic [31:0] s_araddr, r_addr;
   logic [3:0]  s_arlen;
   logic i_act, d_act, w_act, r_act;
   int   widx, ar_wait, aw_wait, r_beat, r_len;
   initial begin
      req_t r;
      inst_rd_req = 0; inst_rd_addr = 0; inst_rd_len = 0;
      data_rd_req = 0; data_rd_addr = 0; data_rd_len = 0; data_rd_size = 0;
      data_wr_req = 0; data_wr_addr = 0; data_wr_len = 0; data_wr_size = 0;
      data_wr_data = 0; data_wr_strb = 0;
      arready = 0; rdata = 0; rlast = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
      i_act = 0; d_act = 0; w_act = 0; r_act = 0; widx = 0; ar_wait = 0; aw_wait = 0;
      r_beat = 0; r_len = 0; r_addr = 0;
      forever begin
         @(negedge clk);
         s_rst = rst; s_igt = inst_rd_gnt; s_dgt = data_rd_gnt; s_wgt = data_wr_gnt;
         s_ar_hs = arvalid && arready; s_arv = arvalid; s_araddr = araddr; s_arlen = arlen;
         s_r_hs = rvalid && rready; s_aw_hs = awvalid && awready; s_awv = awvalid;
         s_wrdy = data_wr_ready; s_wl = wvalid && wready && wlast; s_b_hs = bvalid && bready;
         @(posedge clk);
         #1;
         if (!s_rst || !rst) begin
            inst_rd_req = 0; data_rd_req = 0; data_wr_req = 0;
            arready = 0; rvalid = 0; rlast = 0; rdata = 0; awready = 0; wready = 0; bvalid = 0;
            i_act = 0; d_act = 0; w_act = 0; r_act = 0; widx = 0; ar_wait = 0; aw_wait = 0;
         end else begin
            if (i_act && s_igt) begin inst_rd_req = 0; i_act = 0; end
            if (!i_act && iq.size() > 0) begin
               r = iq.pop_front();
               inst_rd_addr = r.addr; inst_rd_len = r.len; inst_rd_req = 1; i_act = 1;
            end
            if (d_act && s_dgt) begin data_rd_req = 0; d_act = 0; end
            if (!d_act && dq.size() > 0) begin
               r = dq.pop_front();
               data_rd_addr = r.addr; data_rd_len = r.len; data_rd_size = r.size;
               data_rd_req = 1; d_act = 1;
            end
            if (w_act && s_wgt) begin data_wr_req = 0; w_act = 0; widx = 0; end
            else if (s_wrdy && widx < 15) widx++;
            if (!w_act && wq.size() > 0) begin
               r = wq.pop_front();
               data_wr_addr = r.addr; data_wr_len = r.len; data_wr_size = r.size;
               data_wr_req = 1; w_act = 1;
            end
            data_wr_data = wvec[widx];
            data_wr_strb = wstrb_v;
            if (s_ar_hs) begin
               arready = 0; ar_wait = 0;
               r_act = 1; r_addr = s_araddr; r_len = int'(s_arlen); r_beat = 0;
            end else begin
               if (s_arv) begin ar_wait++; arready = (ar_wait >= ar_delay); end
               if (s_r_hs) begin
                  if (rlast) r_act = 0;
                  else r_beat++;
               end
            end
            rvalid = r_act;
            rdata  = r_addr + 32'(r_beat * 4);
            rlast  = r_act && (r_beat == r_len);
            if (s_aw_hs) begin awready = 0; aw_wait = 0; end
            else if (s_awv) begin aw_wait++; awready = (aw_wait >= 1); end
            wready = wr_toggle ? ~wready : 1'b1;
            if (s_wl) bvalid = 1;
            else if (s_b_hs) bvalid = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic rd(input int owner, input logic [31:0] addr, input logic [3:0] len,
                     input logic [2:0] size, input int held, input int gap,
                     input int min_done, input int nb);
      req_t r; ar_t a; rb_t b; gnt_t g;
      r.addr = addr; r.len = len; r.size = size;
      if (owner == 0) iq.push_back(r); else dq.push_back(r);
      g.owner = owner; g.gap = gap; g.min_done = min_done;
      g_exp.push_back(g);
      a.id = (owner == 0) ? 4'd0 : 4'd1; a.addr = addr; a.len = len;
      a.size = (owner == 0) ? 3'd2 : size; a.held = held;
      ar_exp.push_back(a);
      for (int i = 0; i < nb; i++) begin
         b.owner = owner; b.data = addr + 32'(i * 4); b.last = (i == int'(len));
         rb_exp.push_back(b);
      end
   endtask

   task automatic wr(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                     input logic [3:0] strb, input logic [31:0] base);
      req_t r; ar_t a; wb_t w;
      for (int i = 0; i < 16; i++) wvec[i] = base + 32'(i);
      wstrb_v = strb;
      r.addr = addr; r.len = len; r.size = size;
      wq.push_back(r);
      wg_exp.push_back(1);
      a.id = 4'd1; a.addr = addr; a.len = len; a.size = size; a.held = 0;
      aw_exp.push_back(a);
      for (int i = 0; i <= int'(len); i++) begin
         w.data = base + 32'(i); w.strb = strb; w.last = (i == int'(len));
         wb_exp.push_back(w);
      end
      done_exp.push_back(1);
      wr_total++;
   endtask

   function automatic int outstanding();
      return iq.size() + dq.size() + wq.size() + ar_exp.size() + aw_exp.size() +
             rb_exp.size() + g_exp.size() + wb_exp.size() + done_exp.size() + wg_exp.size();
   endfunction

   task automatic wait_idle(input string name, input int maxc);
      int n = 0;
      while (outstanding() != 0 && n < maxc) begin @(posedge clk); n++; end
      check(name, 64'(outstanding()), 64'd0);
      if (outstanding() != 0) begin
         iq.delete(); dq.delete(); wq.delete(); ar_exp.delete(); aw_exp.delete();
         rb_exp.delete(); g_exp.delete(); wb_exp.delete(); done_exp.delete(); wg_exp.delete();
      end
      repeat (3) @(posedge clk);
   endtask

   initial begin
      int n;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;
      @(negedge clk);
      check("reset_ctrl_outputs", {50'd0, arvalid, rready, inst_rd_valid, data_rd_valid, rd_last,
            inst_rd_gnt, data_rd_gnt, awvalid, wvalid, wlast, bready, data_wr_gnt,
            data_wr_ready, data_wr_done}, 64'd0);
      check("reset_ar_fields", {21'd0, arid, araddr, arlen, arsize}, 64'd0);
      check("reset_aw_fields", {21'd0, awid, awaddr, awlen, awsize}, 64'd0);

      // single instruction burst with slow arready
      @(posedge clk);
      ar_delay = 2;
      rd(0, 32'h1FC0_0000, 4'd7, 3'd2, 3, -1, 0, 8);
      wait_idle("drain_inst_burst", 200);

      // round-robin between simultaneous inst/data reads
      @(posedge clk);
      ar_delay = 1;
      rd(0, 32'h1000_0000, 4'd1, 3'd2, 2, -1, 0, 2);
      rd(1, 32'h2000_0040, 4'd2, 3'd2, 2, 1, 0, 3);
      wait_idle("drain_rr_pair1", 200);
      @(posedge clk);
      rd(1, 32'h2000_0080, 4'd1, 3'd2, 2, -1, 0, 2);
      rd(0, 32'h1000_0100, 4'd0, 3'd2, 2, 1, 0, 1);
      wait_idle("drain_rr_pair2", 200);
      @(posedge clk);
      rd(0, 32'h1000_0200, 4'd2, 3'd2, 2, -1, 0, 3);
      rd(1, 32'h2000_00C0, 4'd0, 3'd2, 2, 1, 0, 1);
      wait_idle("drain_rr_pair3", 200);

      // write burst with wready toggling
      @(posedge clk);
      wr_toggle = 1'b1;
      wr(32'h0000_1000, 4'd3, 3'd2, 4'hF, 32'hA000_0000);
      wait_idle("drain_write", 200);
      wr_toggle = 1'b0;

      // data read behind a simultaneous write; inst read proceeds meanwhile
      @(posedge clk);
      wr(32'h0000_2000, 4'd3, 3'd2, 4'h3, 32'hB000_0010);
      rd(0, 32'h1FC0_0200, 4'd3, 3'd2, 2, -1, 0, 4);
      rd(1, 32'h0000_2000, 4'd1, 3'd2, 2, -1, wr_total, 2);
      wait_idle("drain_raw", 300);

      // single-beat byte read
      @(posedge clk);
      rd(1, 32'h0000_3001, 4'd0, 3'd0, 2, -1, 0, 1);
      wait_idle("drain_len0", 100);

      // reset during the third beat of an 8-beat burst
      @(posedge clk);
      rd(0, 32'h1FC0_0400, 4'd7, 3'd2, 2, -1, 0, 2);
      n = 0;
      while (rb_exp.size() != 0 && n < 100) begin @(posedge clk); n++; end
      check("reach_beat2", 64'(rb_exp.size()), 64'd0);
      #2 rst = 1'b0;
      #1;
      check("midreset_outputs", {18'd0, arvalid, rready, inst_rd_valid, data_rd_valid, rd_last,
            rd_data, inst_rd_gnt, data_rd_gnt, awvalid, wvalid, wlast, bready, data_wr_gnt,
            data_wr_ready, data_wr_done}, 64'd0);
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      wait_idle("drain_midreset", 20);

      // arbitration restarts with instruction side favoured
      @(posedge clk);
      rd(0, 32'h1FC0_0800, 4'd1, 3'd2, 2, -1, 0, 2);
      rd(1, 32'h0000_4000, 4'd0, 3'd1, 2, 1, 0, 1);
      wait_idle("drain_post_reset", 200);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
